// File: rtl/gba_rom_bus_slave.sv
// gba_rom_bus_slave: cartridge-side engine for the GBA multiplexed ROM bus.
// Latches the halfword address on nCS, prefetches reads, drives AD, emits writes.
//
// Ports:
//   clock, reset           system clock, synchronous active-low reset
//   gba_nCS/nRD/nWR        raw GBA strobes (asynchronous)
//   gba_AD_in, gba_A_in    raw AD/A pin inputs
//   gba_AD_out, gba_AD_oe  read data and output enable for AD pins
//   gba_A_out, gba_A_oe    A pins are never driven (constant 0)
//   mem_req_*              read request channel to the backing store
//   mem_rsp_*              read response channel (one per accepted request)
//   wr_valid/addr/data     one-cycle write strobe to the backing store
//   underrun               sticky: a read began before data was ready
//   rd_count               serviced read counter
//
// Build option: define GBA_BUS_STATS_EN to enable the saturating rd_count
// counter; otherwise rd_count is tied to 0.

module gba_rom_bus_slave #(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 24
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              gba_nCS,
    input  logic              gba_nRD,
    input  logic              gba_nWR,
    input  logic [15:0]       gba_AD_in,
    input  logic [7:0]        gba_A_in,
    output logic [15:0]       gba_AD_out,
    output logic              gba_AD_oe,
    output logic [7:0]        gba_A_out,
    output logic              gba_A_oe,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [15:0]       mem_rsp_data,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              underrun,
    output logic [31:0]       rd_count
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WAIT_RSP,
        READY
    } state_t;

    state_t state;
    state_t state_d;

    // Synchroniser chains; AD/A use the same depth as the strobes so
    // the sampled address lines up with the synced nCS edge.
    logic [SYNC_STAGES-1:0] ncs_q;
    logic [SYNC_STAGES-1:0] nrd_q;
    logic [SYNC_STAGES-1:0] nwr_q;
    logic [15:0]            ad_q [SYNC_STAGES];
    logic [7:0]             a_q  [SYNC_STAGES];

    logic ncs_s, nrd_s, nwr_s;
    logic ncs_p, nrd_p, nwr_p;
    logic [15:0] ad_s;
    logic [7:0]  a_s;

    logic ncs_fall, ncs_rise;
    logic rd_fall, rd_rise, wr_rise;
    logic rd_step, wr_step, step;
    logic req_fire;

    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_d;
    logic [ADDR_W-1:0] req_addr;
    logic [15:0]       data_reg;
    logic              pending_rsp;
    logic              ad_oe;

    always_ff @(posedge clock) begin
        if (!reset) begin
            ncs_q <= '1;
            nrd_q <= '1;
            nwr_q <= '1;
            ncs_p <= 1'b1;
            nrd_p <= 1'b1;
            nwr_p <= 1'b1;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                ad_q[i] <= '0;
                a_q[i]  <= '0;
            end
        end else begin
            ncs_q <= {ncs_q[SYNC_STAGES-2:0], gba_nCS};
            nrd_q <= {nrd_q[SYNC_STAGES-2:0], gba_nRD};
            nwr_q <= {nwr_q[SYNC_STAGES-2:0], gba_nWR};
            ncs_p <= ncs_s;
            nrd_p <= nrd_s;
            nwr_p <= nwr_s;
            ad_q[0] <= gba_AD_in;
            a_q[0]  <= gba_A_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                ad_q[i] <= ad_q[i-1];
                a_q[i]  <= a_q[i-1];
            end
        end
    end

    assign ncs_s = ncs_q[SYNC_STAGES-1];
    assign nrd_s = nrd_q[SYNC_STAGES-1];
    assign nwr_s = nwr_q[SYNC_STAGES-1];
    assign ad_s  = ad_q[SYNC_STAGES-1];
    assign a_s   = a_q[SYNC_STAGES-1];

    assign ncs_fall = ncs_p & ~ncs_s;
    assign ncs_rise = ~ncs_p & ncs_s;
    assign rd_fall  = nrd_p & ~nrd_s;
    assign rd_rise  = ~nrd_p & nrd_s;
    assign wr_rise  = ~nwr_p & nwr_s;

    // Strobe rises only count while selected; a simultaneous nCS rise
    // makes ncs_s high, so deselection always wins.
    assign rd_step = rd_rise & ~ncs_s & (state != IDLE);
    assign wr_step = wr_rise & ~ncs_s & (state != IDLE);
    assign step    = rd_step | wr_step;

    assign req_fire = mem_req_valid & mem_req_ready;

    // State register
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state. An accepted request whose address was overtaken by a
    // step while it was held stays in FETCH; its response is discarded
    // and a fresh request goes out once pending_rsp clears.
    always_comb begin
        state_d = state;
        if (ncs_rise) begin
            state_d = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (ncs_fall) state_d = FETCH;
                end
                FETCH: begin
                    if (!step && req_fire && req_addr == addr)
                        state_d = WAIT_RSP;
                end
                WAIT_RSP: begin
                    if (step) state_d = FETCH;
                    else if (mem_rsp_valid) state_d = READY;
                end
                READY: begin
                    if (step) state_d = FETCH;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs. No new request while an earlier response is outstanding.
    always_comb begin
        mem_req_valid = (state == FETCH) && !pending_rsp;
    end

    always_comb begin
        addr_d = addr;
        if (state == IDLE && ncs_fall) begin
            addr_d = ADDR_W'({a_s, ad_s});
        end else if (step) begin
            addr_d = addr + ADDR_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            addr        <= '0;
            req_addr    <= '0;
            data_reg    <= '0;
            pending_rsp <= 1'b0;
            ad_oe       <= 1'b0;
            wr_valid    <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            underrun    <= 1'b0;
        end else begin
            addr <= addr_d;
            // Request address is frozen while the request is offered.
            if (!(mem_req_valid && !mem_req_ready)) begin
                req_addr <= addr_d;
            end
            if (req_fire) begin
                pending_rsp <= 1'b1;
            end else if (mem_rsp_valid) begin
                pending_rsp <= 1'b0;
            end
            // Responses arriving outside WAIT_RSP are stale and dropped.
            if (state == WAIT_RSP && mem_rsp_valid) begin
                data_reg <= mem_rsp_data;
            end
            ad_oe    <= ~ncs_s & ~nrd_s & nwr_s;
            wr_valid <= wr_step;
            if (wr_step) begin
                wr_addr <= addr;
                wr_data <= ad_s;
            end
            // nRD is shared with other GBA regions, so only selected
            // reads can underrun.
            if (rd_fall && !ncs_s && state != READY) begin
                underrun <= 1'b1;
            end
        end
    end

    assign gba_AD_oe    = ad_oe;
    assign gba_AD_out   = ad_oe ? data_reg : 16'h0000;
    assign gba_A_out    = 8'h00;
    assign gba_A_oe     = 1'b0;
    assign mem_req_addr = req_addr;

`ifdef GBA_BUS_STATS_EN
    logic [31:0] rd_cnt;

    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_cnt <= '0;
        end else if (rd_step && rd_cnt != 32'hFFFF_FFFF) begin
            rd_cnt <= rd_cnt + 32'd1;
        end
    end

    assign rd_count = rd_cnt;
`else
    assign rd_count = 32'h0;
`endif

endmodule
